// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for a register-file/ALU datapath.
// Define ALU_CMP_EN to make ALUop=01 a compare that skips write-back.
module alu_seq_ctrl #(
    parameter logic [2:0] OPC_ALU = 3'b101
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] instr,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        WRITE
    } state_t;

    state_t     state;

    // latched fields still needed after the accepting edge
    logic [1:0] ir_aluop;
    logic [2:0] ir_rd;
    logic [1:0] ir_shift;
    logic [2:0] ir_rm;

    logic       is_cmp;

`ifdef ALU_CMP_EN
    assign is_cmp = (ir_aluop == 2'b01);
`else
    assign is_cmp = 1'b0;
`endif

    // state walk; outputs are set for the state being entered
    always_ff @(posedge clk) begin
        readnum  <= '0;
        writenum <= '0;
        write    <= 1'b0;
        loada    <= 1'b0;
        loadb    <= 1'b0;
        loadc    <= 1'b0;
        loads    <= 1'b0;
        ALUop    <= '0;
        shift    <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
        err      <= 1'b0;
        if (!reset_n) begin
            state    <= IDLE;
            ir_aluop <= '0;
            ir_rd    <= '0;
            ir_shift <= '0;
            ir_rm    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ir_aluop <= instr[12:11];
                        ir_rd    <= instr[7:5];
                        ir_shift <= instr[4:3];
                        ir_rm    <= instr[2:0];
                        if (instr[15:13] != OPC_ALU) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (instr[12:11] == 2'b11) begin
                            state   <= GET_B;
                            readnum <= instr[2:0];
                            loadb   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state   <= GET_A;
                            readnum <= instr[10:8];
                            loada   <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                GET_A: begin
                    state   <= GET_B;
                    readnum <= ir_rm;
                    loadb   <= 1'b1;
                    busy    <= 1'b1;
                end
                GET_B: begin
                    state <= EXEC;
                    ALUop <= ir_aluop;
                    shift <= ir_shift;
                    loadc <= !is_cmp;
                    loads <= 1'b1;
                    busy  <= 1'b1;
                end
                EXEC: begin
                    if (is_cmp) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state    <= WRITE;
                        writenum <= ir_rd;
                        write    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter OPC_ALU, default 3'b101, meaning the opcode value in instr[15:13] that selects ALU instructions.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to execute instr.
REQ-005 SHALL have port instr, input, 16, instruction fields: [15:13] opcode, [12:11] ALUop, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm.
REQ-006 SHALL have port readnum, output, 3, register-file read address.
REQ-007 SHALL have ports writenum (output, 3) and write (output, 1): register-file write address and write enable.
REQ-008 SHALL have ports loada, loadb, loadc and loads (output, 1 each): load enables for operand A, operand B, result and status registers.
REQ-009 SHALL have ports ALUop (output, 2) and shift (output, 2): ALU operation select and B-path shift select.
REQ-010 SHALL have ports busy, done and err (output, 1 each): busy = instruction in flight; done = one-cycle completion pulse; err = one-cycle illegal-opcode pulse.

Function
REQ-011 SHALL implement the states IDLE, GET_A, GET_B, EXEC and WRITE, held in a registered state variable.
REQ-012 In IDLE with start=1, SHALL latch instr into an internal register on that edge; start SHALL be ignored in every other state.
REQ-013 On acceptance with an opcode other than OPC_ALU, SHALL return to IDLE with err=1 and done=1 for exactly the next cycle, and no load or write enables asserted.
REQ-014 Transitions SHALL be: IDLE->GET_A on accept, except ALUop=11 (MVN), which goes IDLE->GET_B.
REQ-015 Remaining transitions SHALL be: GET_A->GET_B; GET_B->EXEC; EXEC->WRITE; WRITE->IDLE. Each state lasts exactly one cycle.
REQ-016 In GET_A, SHALL drive readnum=Rn and loada=1.
REQ-017 In GET_B, SHALL drive readnum=Rm and loadb=1.
REQ-018 In EXEC, SHALL drive ALUop and shift from the latched instruction, with loadc=1 and loads=1.
REQ-019 In WRITE, SHALL drive writenum=Rd and write=1.
REQ-020 Outside the states named in REQ-016 to REQ-019, readnum, writenum, ALUop and shift SHALL be 0 and all enables SHALL be 0.
REQ-021 busy SHALL be 1 in every state other than IDLE.
REQ-022 done SHALL be a registered pulse, high for exactly the first IDLE cycle after a completed or rejected instruction.
REQ-023 Latency from the accepting edge to done high SHALL be: 5 cycles for ADD/SUB/AND, 4 for MVN, 1 for an illegal opcode.
REQ-024 start held high continuously SHALL cause a new acceptance in each IDLE cycle, including the cycle in which done=1, giving back-to-back execution.
REQ-025 Changes on instr after acceptance SHALL NOT affect the instruction in flight.

Reset
REQ-026 While reset_n=0 at a rising edge, state SHALL become IDLE and the latched instruction SHALL be cleared to 0.
REQ-027 After reset, every output SHALL be 0, including done and err.
REQ-028 Reset asserted mid-instruction SHALL abort it: no further write, no done pulse.
REQ-029 reset_n SHALL take priority over start on the same edge.

Configuration
REQ-030 Macro ALU_CMP_EN SHALL control compare behaviour for ALUop=01.
REQ-031 With ALU_CMP_EN defined, ALUop=01 SHALL be CMP: EXEC asserts loads=1 and loadc=0, then goes directly to IDLE with no WRITE state, so latency is 4 cycles.
REQ-032 Without ALU_CMP_EN, ALUop=01 SHALL be SUB and follow REQ-015 to REQ-019 unchanged.

Verification
REQ-033 ADD: instr=16'b101_00_001_010_00_011, start 1 cycle -> readnum=1 with loada; readnum=3 with loadb; ALUop=00 with loadc and loads; writenum=2 with write; done on cycle 5.
REQ-034 MVN: instr=16'b101_11_000_101_01_110 -> GET_A skipped; readnum=6 with loadb; ALUop=11 and shift=01 in EXEC; writenum=5; done on cycle 4.
REQ-035 Illegal opcode: instr=16'h0000 with start -> next cycle err=1 and done=1, no enables ever high, busy stays 0.
REQ-036 ALUop=01: with ALU_CMP_EN -> loads=1, loadc=0, write never asserted, done on cycle 4; without it -> write with writenum=Rd, done on cycle 5.
REQ-037 Reset during EXEC -> next cycle all outputs 0 and no write or done; then start toggling while busy -> ignored; start held high -> second instruction accepted on the done cycle.
